// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem request handshake, IF/ID register
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HALT_OPC = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc2,
    output logic        if_valid,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DROP = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drop_addr_q, drop_addr_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc2_q, if_pc2_d;
    logic        if_valid_q, if_valid_d;
    logic        err_q, err_d;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            drop_addr_q <= 16'h0000;
            if_instr_q  <= 16'h0000;
            if_pc2_q    <= 16'h0000;
            if_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            if_instr_q  <= if_instr_d;
            if_pc2_q    <= if_pc2_d;
            if_valid_q  <= if_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        if_instr_d  = if_instr_q;
        if_pc2_d    = if_pc2_q;
        if_valid_d  = if_valid_q;
        err_d       = err_q;

        // decode consumed the current word; a same-cycle response overwrites below
        if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            if (redirect_pc[0]) begin
                err_d = 1'b1;
            end
            if (imem_req && !imem_ready) begin
                state_d = S_DROP;
                // a redirect already in DROP keeps tracking the original stale address
                if (state_q != S_DROP) begin
                    drop_addr_d = imem_addr;
                end
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (imem_req && imem_ready) begin
                        if_instr_d = imem_rdata;
                        if_pc2_d   = pc_plus2;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus2;
                        if (imem_rdata[15:11] == HALT_OPC) begin
                            state_d = S_HALT;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ready) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        halted    = 1'b0;
        case (state_q)
            S_RUN:  imem_req = ~if_valid_q | ~stall;
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            S_HALT: halted = 1'b1;
            default: begin
            end
        endcase
    end

    assign if_instr = if_instr_q;
    assign if_pc2   = if_pc2_q;
    assign if_valid = if_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc2;
    logic        if_valid;
    logic        halted;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int vec_idx  = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_instr    (if_instr),
        .if_pc2      (if_pc2),
        .if_valid    (if_valid),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        logic        e_valid;
        logic        e_halt;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(logic st, logic rd, logic [15:0] rpc, logic rdy,
                                logic [15:0] rdata, logic e_req, logic [15:0] e_addr,
                                logic [15:0] e_instr, logic [15:0] e_pc2,
                                logic e_valid, logic e_halt, logic e_err);
        vec_t v;
        v.stall = st;  v.redir = rd;  v.rpc = rpc;  v.rdy = rdy;  v.rdata = rdata;
        v.e_req = e_req;  v.e_addr = e_addr;  v.e_instr = e_instr;  v.e_pc2 = e_pc2;
        v.e_valid = e_valid;  v.e_halt = e_halt;  v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, vec_idx, act, exp);
        end
    endtask

    // inputs driven mid-low-phase; request checked before the edge, IF/ID after it
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        imem_ready  = v.rdy;
        imem_rdata  = v.rdata;
        #1;
        chk("imem_req",  {15'd0, imem_req}, {15'd0, v.e_req});
        chk("imem_addr", imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        chk("if_instr", if_instr, v.e_instr);
        chk("if_pc2",   if_pc2,   v.e_pc2);
        chk("if_valid", {15'd0, if_valid}, {15'd0, v.e_valid});
        chk("halted",   {15'd0, halted},   {15'd0, v.e_halt});
        chk("err",      {15'd0, err},      {15'd0, v.e_err});
        vec_idx++;
    endtask

    vec_t vt[25];

    initial begin
        //            st rd rpc       rdy rdata     req addr      instr     pc2      v  h  e
        vt[0]  = mk(0, 0, 16'h0000, 1, 16'h4000, 1, 16'h0000, 16'h4000, 16'h0002, 1, 0, 0);
        vt[1]  = mk(0, 0, 16'h0000, 1, 16'h4002, 1, 16'h0002, 16'h4002, 16'h0004, 1, 0, 0);
        vt[2]  = mk(0, 0, 16'h0000, 1, 16'h4004, 1, 16'h0004, 16'h4004, 16'h0006, 1, 0, 0);
        vt[3]  = mk(1, 0, 16'h0000, 1, 16'h4006, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 0);
        vt[4]  = mk(1, 0, 16'h0000, 1, 16'h4006, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 0);
        vt[5]  = mk(1, 0, 16'h0000, 1, 16'h4006, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0, 0);
        vt[6]  = mk(0, 0, 16'h0000, 1, 16'h4006, 1, 16'h0006, 16'h4006, 16'h0008, 1, 0, 0);
        vt[7]  = mk(0, 0, 16'h0000, 0, 16'h4008, 1, 16'h0008, 16'h4006, 16'h0008, 0, 0, 0);
        vt[8]  = mk(0, 1, 16'h0100, 0, 16'h4008, 1, 16'h0008, 16'h4006, 16'h0008, 0, 0, 0);
        vt[9]  = mk(0, 0, 16'h0000, 0, 16'h4008, 1, 16'h0008, 16'h4006, 16'h0008, 0, 0, 0);
        vt[10] = mk(0, 0, 16'h0000, 1, 16'h4008, 1, 16'h0008, 16'h4006, 16'h0008, 0, 0, 0);
        vt[11] = mk(0, 0, 16'h0000, 1, 16'h4100, 1, 16'h0100, 16'h4100, 16'h0102, 1, 0, 0);
        vt[12] = mk(1, 1, 16'h0200, 1, 16'h4102, 0, 16'h0102, 16'h4100, 16'h0102, 0, 0, 0);
        vt[13] = mk(0, 0, 16'h0000, 1, 16'h4200, 1, 16'h0200, 16'h4200, 16'h0202, 1, 0, 0);
        vt[14] = mk(0, 1, 16'h0006, 1, 16'h4202, 1, 16'h0202, 16'h4200, 16'h0202, 0, 0, 0);
        vt[15] = mk(0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0006, 16'h0000, 16'h0008, 1, 1, 0);
        vt[16] = mk(0, 0, 16'h0000, 1, 16'h4008, 0, 16'h0008, 16'h0000, 16'h0008, 0, 1, 0);
        vt[17] = mk(0, 0, 16'h0000, 1, 16'h4008, 0, 16'h0008, 16'h0000, 16'h0008, 0, 1, 0);
        vt[18] = mk(0, 1, 16'h0020, 0, 16'h4008, 0, 16'h0008, 16'h0000, 16'h0008, 0, 0, 0);
        vt[19] = mk(0, 0, 16'h0000, 1, 16'h4020, 1, 16'h0020, 16'h4020, 16'h0022, 1, 0, 0);
        vt[20] = mk(0, 1, 16'h0013, 0, 16'h4022, 1, 16'h0022, 16'h4020, 16'h0022, 0, 0, 1);
        vt[21] = mk(0, 0, 16'h0000, 1, 16'h4022, 1, 16'h0022, 16'h4020, 16'h0022, 0, 0, 1);
        vt[22] = mk(0, 1, 16'hFFFE, 1, 16'h4013, 1, 16'h0013, 16'h4020, 16'h0022, 0, 0, 1);
        vt[23] = mk(0, 0, 16'h0000, 1, 16'h1234, 1, 16'hFFFE, 16'h1234, 16'h0000, 1, 0, 1);
        vt[24] = mk(0, 0, 16'h0000, 1, 16'h4000, 1, 16'h0000, 16'h4000, 16'h0002, 1, 0, 1);

        rst = 1'b0;  stall = 1'b0;  redirect = 1'b0;  redirect_pc = 16'h0000;
        imem_ready = 1'b0;  imem_rdata = 16'h0000;
        #12;
        chk("rst_if_instr", if_instr, 16'h0000);
        chk("rst_if_pc2",   if_pc2,   16'h0000);
        chk("rst_if_valid", {15'd0, if_valid}, 16'h0000);
        chk("rst_halted",   {15'd0, halted},   16'h0000);
        chk("rst_err",      {15'd0, err},      16'h0000);
        chk("rst_addr",     imem_addr, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            run_vec(vt[i]);
        end

        // asynchronous reset in the middle of an outstanding request
        @(negedge clk);
        imem_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_if_valid", {15'd0, if_valid}, 16'h0000);
        chk("midrst_err",      {15'd0, err},      16'h0000);
        chk("midrst_addr",     imem_addr, 16'h0000);
        chk("midrst_if_instr", if_instr, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // second redirect while draining a stale request
        run_vec(mk(0, 1, 16'h0100, 0, 16'h4000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        run_vec(mk(0, 1, 16'h0200, 0, 16'h4000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        run_vec(mk(0, 0, 16'h0000, 1, 16'h4000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        run_vec(mk(0, 0, 16'h0000, 1, 16'h4200, 1, 16'h0200, 16'h4200, 16'h0202, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
